// File: rtl/char_writer.sv
// Writer side of the 80x25 char buffer: byte stream in, cursor/control handling, clear and scroll.
// Optional build macro CHAR_WRITER_AUTOWRAP_EN: wrap to the next line after the last column.
module char_writer #(
    parameter int                    COLS       = 80,
    parameter int                    ROWS       = 25,
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] BLANK      = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  cmd_clear,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    output logic [DATA_WIDTH-1:0] buf_din,
    output logic                  buf_we,
    input  logic [DATA_WIDTH-1:0] buf_dout,
    output logic [6:0]            cursor_x,
    output logic [4:0]            cursor_y,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WRITE,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_SCROLL_FILL
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] L_CELLS       = ADDR_WIDTH'(COLS * ROWS);
    localparam logic [ADDR_WIDTH-1:0] L_LAST_CELL   = ADDR_WIDTH'(COLS * ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] L_COPY_LAST   = ADDR_WIDTH'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] L_FILL_FIRST  = ADDR_WIDTH'((ROWS - 1) * COLS);
    localparam logic [ADDR_WIDTH-1:0] L_COLS        = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] L_ONE         = ADDR_WIDTH'(1);
    localparam logic [6:0]            L_X_MAX       = 7'(COLS - 1);
    localparam logic [4:0]            L_Y_MAX       = 5'(ROWS - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_we;
    logic                  r_din_sel;
    logic                  r_scroll_pend;
    logic [6:0]            r_x;
    logic [4:0]            r_y;

    logic [ADDR_WIDTH-1:0] w_row_base;
    logic [ADDR_WIDTH-1:0] w_char_addr;
    logic                  w_printable;

    // Row base y*80 as two shifts; the largest cell index (1999) fits the address width.
    assign w_row_base  = ADDR_WIDTH'({r_y, 6'b0}) + ADDR_WIDTH'({r_y, 4'b0});
    assign w_char_addr = w_row_base + ADDR_WIDTH'(r_x);
    assign w_printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

    assign in_ready = (r_state == ST_IDLE) && !cmd_clear;
    assign busy     = (r_state != ST_IDLE);
    assign buf_addr = r_addr;
    assign buf_we   = r_we;
    // During a copy write the RAM read data lands in the same cycle, so it bypasses the register.
    assign buf_din  = r_din_sel ? buf_dout : r_din;
    assign cursor_x = r_x;
    assign cursor_y = r_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_CLEAR;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_din         <= '0;
            r_we          <= 1'b0;
            r_din_sel     <= 1'b0;
            r_scroll_pend <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_x <= '0;
                    r_y <= '0;
                    if (r_cnt == L_CELLS) begin
                        r_state <= ST_IDLE;
                        r_we    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_we   <= 1'b1;
                        r_addr <= r_cnt;
                        r_din  <= BLANK;
                        r_cnt  <= r_cnt + L_ONE;
                    end
                end

                ST_IDLE: begin
                    r_we <= 1'b0;
                    if (cmd_clear) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                    end else if (in_valid) begin
                        r_state       <= ST_WRITE;
                        r_scroll_pend <= 1'b0;
                        if (w_printable) begin
                            r_we   <= 1'b1;
                            r_addr <= w_char_addr;
                            r_din  <= in_data;
                            if (r_x < L_X_MAX) begin
                                r_x <= r_x + 7'd1;
                            end else begin
`ifdef CHAR_WRITER_AUTOWRAP_EN
                                r_x <= '0;
                                if (r_y < L_Y_MAX) r_y <= r_y + 5'd1;
                                else               r_scroll_pend <= 1'b1;
`else
                                r_x <= r_x;
`endif
                            end
                        end else if (in_data == 8'h0D) begin
                            r_x <= '0;
                        end else if (in_data == 8'h08) begin
                            if (r_x != 7'd0) r_x <= r_x - 7'd1;
                        end else if (in_data == 8'h0A) begin
                            if (r_y < L_Y_MAX) r_y <= r_y + 5'd1;
                            else               r_scroll_pend <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    r_we <= 1'b0;
                    if (r_scroll_pend) begin
                        r_state       <= ST_SCROLL_RD;
                        r_scroll_pend <= 1'b0;
                        r_cnt         <= '0;
                        r_addr        <= L_COLS;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_SCROLL_RD: begin
                    r_state   <= ST_SCROLL_WR;
                    r_addr    <= r_cnt;
                    r_we      <= 1'b1;
                    r_din_sel <= 1'b1;
                end

                ST_SCROLL_WR: begin
                    r_din_sel <= 1'b0;
                    if (r_cnt == L_COPY_LAST) begin
                        r_state <= ST_SCROLL_FILL;
                        r_addr  <= L_FILL_FIRST;
                        r_din   <= BLANK;
                        r_we    <= 1'b1;
                    end else begin
                        r_state <= ST_SCROLL_RD;
                        r_cnt   <= r_cnt + L_ONE;
                        r_addr  <= r_cnt + L_ONE + L_COLS;
                        r_we    <= 1'b0;
                    end
                end

                ST_SCROLL_FILL: begin
                    if (r_addr == L_LAST_CELL) begin
                        r_state <= ST_IDLE;
                        r_we    <= 1'b0;
                    end else begin
                        r_addr <= r_addr + L_ONE;
                    end
                end

                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_writer.sv
// Directed bench for char_writer: RAM model, byte scoreboard, clear/scroll/reset checks.
module tb_char_writer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        cmd_clear;
    logic [10:0] buf_addr;
    logic [7:0]  buf_din;
    logic        buf_we;
    logic [7:0]  buf_dout;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int mx = 0;
    int my = 0;

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [7:0]  data;
        logic [6:0]  x;
        logic [4:0]  y;
    } exp_t;

    exp_t sb[$];

    logic [7:0] mem [0:2047];

    char_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd_clear (cmd_clear),
        .buf_addr  (buf_addr),
        .buf_din   (buf_din),
        .buf_we    (buf_we),
        .buf_dout  (buf_dout),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with registered read, like the real char buffer.
    always @(posedge clk) begin
        if (buf_we) mem[buf_addr] <= buf_din;
        buf_dout <= mem[buf_addr];
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [7:0] b, output exp_t e);
        e.we   = 1'b0;
        e.addr = '0;
        e.data = '0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            e.we   = 1'b1;
            e.addr = 11'(my * 80 + mx);
            e.data = b;
            if (mx < 79) begin
                mx++;
            end else begin
`ifdef CHAR_WRITER_AUTOWRAP_EN
                mx = 0;
                if (my < 24) my++;
`endif
            end
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h08) begin
            if (mx > 0) mx--;
        end else if (b == 8'h0A) begin
            if (my < 24) my++;
        end
        e.x = 7'(mx);
        e.y = 5'(my);
    endtask

    // Returns #1 into the cycle after acceptance (the WRITE cycle).
    task automatic send(input logic [7:0] b);
        exp_t e;
        int   t;
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 6000);
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        model(b, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = sb.pop_front();
        chk("wr_we", 32'(buf_we), 32'(e.we));
        if (e.we) begin
            chk("wr_addr", 32'(buf_addr), 32'(e.addr));
            chk("wr_data", 32'(buf_din), 32'(e.data));
        end
        chk("cur_x", 32'(cursor_x), 32'(e.x));
        chk("cur_y", 32'(cursor_y), 32'(e.y));
        $display("TX byte=%02h we=%0d addr=%0d din=%02h cursor=(%0d,%0d)",
                 b, buf_we, buf_addr, buf_din, cursor_x, cursor_y);
    endtask

    // Call with the first clear write due at the next posedge.
    task automatic clear_check(input string tag);
        int cnt = 0;
        int bad = 0;
        for (int i = 0; i < 2100; i++) begin
            @(posedge clk);
            #1;
            if (buf_we) begin
                if (buf_addr != 11'(cnt) || buf_din != 8'h20) bad++;
                cnt++;
            end
            if (!busy) break;
        end
        mx = 0;
        my = 0;
        chk({tag, "_writes"}, 32'(cnt), 32'd2000);
        chk({tag, "_badwr"}, 32'(bad), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_x"}, 32'(cursor_x), 32'd0);
        chk({tag, "_y"}, 32'(cursor_y), 32'd0);
        $display("TX clear %s writes=%0d", tag, cnt);
    endtask

    initial begin
        int n;
        int w;
        logic [6:0] exp_x;
        logic [4:0] exp_y;

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        cmd_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(buf_we), 32'd0);
        chk("rst_addr", 32'(buf_addr), 32'd0);
        chk("rst_din", 32'(buf_din), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_x", 32'(cursor_x), 32'd0);
        chk("rst_y", 32'(cursor_y), 32'd0);

        // Power-up clear
        @(negedge clk);
        rst_n = 1'b1;
        clear_check("boot");

        // "AB" at home
        send(8'h41);
        send(8'h42);

        // Move to (5,3), then CR / LF / BS-saturate / ignored bytes
        send(8'h0D);
        repeat (3) send(8'h0A);
        repeat (5) send(8'h20);
        send(8'h0D);
        send(8'h0A);
        send(8'h08);
        send(8'h01);
        send(8'h7F);

        // cmd_clear wins over a simultaneous byte
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        cmd_clear = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        #1;
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        cmd_clear = 1'b0;
        in_valid  = 1'b0;
        chk("clr_busy", 32'(busy), 32'd1);
        clear_check("cmd");
        chk("clr_mem0", 32'(mem[0]), 32'h20);

        // Scroll: 'X' at row 1 ends up at row 0
        send(8'h0A);
        send(8'h58);
        repeat (23) send(8'h0A);
        send(8'h0A);
        n = 1;
        w = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
            n++;
            if (buf_we) w++;
        end
        // One WRITE cycle for the LF plus 3920 scroll cycles
        chk("scroll_busy", 32'(n), 32'd3921);
        chk("scroll_writes", 32'(w), 32'd2000);
        chk("scroll_mem0", 32'(mem[0]), 32'h58);
        chk("scroll_mem80", 32'(mem[80]), 32'h20);
        chk("scroll_mem1999", 32'(mem[1999]), 32'h20);
        chk("scroll_x", 32'(cursor_x), 32'd1);
        chk("scroll_y", 32'(cursor_y), 32'd24);
        $display("TX scroll busy=%0d writes=%0d", n, w);

        // Reset pulse in the middle of a scroll
        send(8'h0A);
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(buf_we), 32'd0);
        chk("arst_addr", 32'(buf_addr), 32'd0);
        chk("arst_din", 32'(buf_din), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd1);
        chk("arst_x", 32'(cursor_x), 32'd0);
        chk("arst_y", 32'(cursor_y), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_check("rearm");

        // 80 printables across row 0
        for (int i = 0; i < 80; i++) send(8'(8'h61 + (i % 26)));
        @(posedge clk);
        #1;
`ifdef CHAR_WRITER_AUTOWRAP_EN
        exp_x = 7'd0;
        exp_y = 5'd1;
`else
        exp_x = 7'd79;
        exp_y = 5'd0;
`endif
        chk("row_x", 32'(cursor_x), 32'(exp_x));
        chk("row_y", 32'(cursor_y), 32'(exp_y));
        chk("row_mem79", 32'(mem[79]), 32'h62);
        chk("row_mem0", 32'(mem[0]), 32'h61);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
